// File: rtl/awb_gain_est_if.sv
// awb_gain_est_if
// Pixel stream shared by the white-balance stage and the gain estimator.
//   valid_i : pixel qualifier
//   color_i : channel code (0=R, 1=G, 2=B, 3=ignored)
//   value_i : 8-bit pixel value
//   last_i  : final pixel of frame, meaningful only with valid_i=1
// Modports: master drives the stream, slave snoops it.
interface awb_gain_est_if;
    logic       valid_i;
    logic [1:0] color_i;
    logic [7:0] value_i;
    logic       last_i;

    modport master (output valid_i, color_i, value_i, last_i);
    modport slave  (input  valid_i, color_i, value_i, last_i);
endinterface

// File: rtl/awb_gain_est.sv
// awb_gain_est
// Gray-world auto-white-balance gain estimator. Accumulates per-channel sums
// and pixel counts over a frame, then derives R and B gains relative to G
// with a 16-step restoring divider. Gains are unsigned 8.8 fixed point.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active high
//   pix          : pixel stream (awb_gain_est_if.slave)
//   K_R/K_G/K_B  : per-channel gains, 8.8 unsigned (K_G fixed at unity)
//   valid_gain_o : gains valid, level, set on first update until reset
//   busy_o       : divider running (DIV_R, DIV_B, UPDATE)
//   overrun_o    : sticky, a frame closed while busy
// Optional feature macro: AWB_GAIN_CLAMP_EN clamps K_R/K_B to [0.5, 4.0].
module awb_gain_est #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    awb_gain_est_if.slave   pix,
    output logic [15:0]     K_R,
    output logic [15:0]     K_G,
    output logic [15:0]     K_B,
    output logic            valid_gain_o,
    output logic            busy_o,
    output logic            overrun_o
);
    localparam int PW = ACC_W + CNT_W;  // snapshot product width
    localparam int DW = PW + 16;        // divider working width

    typedef enum logic [1:0] {ACCUM, DIV_R, DIV_B, UPDATE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        iter_reg;
    logic              close_w;
    logic [ACC_W-1:0]  sum_fin [3];
    logic [CNT_W-1:0]  cnt_fin [3];

    assign close_w = pix.valid_i & pix.last_i;
    assign K_G     = 16'h0100;

    // Per-channel accumulators. sum_fin/cnt_fin include the pixel being
    // accepted this cycle, so the closing pixel lands in the snapshot.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic             hit;
        logic [ACC_W-1:0] sum_reg;
        logic [CNT_W-1:0] cnt_reg;

        assign hit         = pix.valid_i && (pix.color_i == 2'(gi));
        assign sum_fin[gi] = sum_reg + (hit ? ACC_W'(pix.value_i) : '0);
        assign cnt_fin[gi] = cnt_reg + (hit ? CNT_W'(1) : '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_reg <= '0;
                cnt_reg <= '0;
            end else if (close_w) begin
                sum_reg <= '0;
                cnt_reg <= '0;
            end else begin
                sum_reg <= sum_fin[gi];
                cnt_reg <= cnt_fin[gi];
            end
        end
    end

    // Cross-multiplied ratios: K_R = (sum_G/cnt_G)/(sum_R/cnt_R) = N_R/D_R
    logic [PW-1:0] n_r_w, d_r_w, n_b_w, d_b_w;
    assign n_r_w = PW'(sum_fin[1]) * PW'(cnt_fin[0]);
    assign d_r_w = PW'(sum_fin[0]) * PW'(cnt_fin[1]);
    assign n_b_w = PW'(sum_fin[1]) * PW'(cnt_fin[2]);
    assign d_b_w = PW'(sum_fin[2]) * PW'(cnt_fin[1]);

    logic [PW-1:0] n_b_reg, d_b_reg;
    logic [DW-1:0] rem_reg, dsh_reg;
    logic [15:0]   q_reg, q_r_reg, q_b_reg;
    logic          ovf_reg, dz_reg;

    // Divider load: R operands straight from the close-time products,
    // B operands from the snapshot taken at the same close.
    logic          div_load;
    logic [PW-1:0] ld_n, ld_d;
    logic          ld_ovf, ld_dz;
    assign div_load = ((state_reg == ACCUM) && close_w) ||
                      ((state_reg == DIV_R) && (iter_reg == 4'd15));
    assign ld_n     = (state_reg == ACCUM) ? n_r_w : n_b_reg;
    assign ld_d     = (state_reg == ACCUM) ? d_r_w : d_b_reg;
    assign ld_ovf   = ({8'd0, ld_n} >= {ld_d, 8'd0});
    assign ld_dz    = (ld_d == '0);

    // One restoring step: divisor pre-shifted by 15 and walked down, so the
    // remainder starts as N*256 and quotient bits emerge MSB first.
    logic          ge_w;
    logic [DW-1:0] rem_step;
    logic [15:0]   q_step;
    assign ge_w     = (rem_reg >= dsh_reg);
    assign rem_step = ge_w ? (rem_reg - dsh_reg) : rem_reg;
    assign q_step   = {q_reg[14:0], ge_w};

    function automatic logic [15:0] finish_q(input logic [15:0] q,
                                             input logic ovf, input logic dz);
        logic [15:0] r;
        if (dz)
            r = 16'h0100;
        else if (ovf || (q > 16'h0FFF))
            r = 16'h0FFF;
        else
            r = q;
`ifdef AWB_GAIN_CLAMP_EN
        if (r < 16'h0080)
            r = 16'h0080;
        else if (r > 16'h0400)
            r = 16'h0400;
`endif
        return r;
    endfunction

    always_comb begin
        state_next = state_reg;
        busy_o     = (state_reg != ACCUM);
        case (state_reg)
            ACCUM:   if (close_w) state_next = DIV_R;
            DIV_R:   if (iter_reg == 4'd15) state_next = DIV_B;
            DIV_B:   if (iter_reg == 4'd15) state_next = UPDATE;
            UPDATE:  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ACCUM;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_reg     <= '0;
            n_b_reg      <= '0;
            d_b_reg      <= '0;
            rem_reg      <= '0;
            dsh_reg      <= '0;
            q_reg        <= '0;
            ovf_reg      <= 1'b0;
            dz_reg       <= 1'b0;
            q_r_reg      <= '0;
            q_b_reg      <= '0;
            K_R          <= 16'h0100;
            K_B          <= 16'h0100;
            valid_gain_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (close_w && (state_reg != ACCUM))
                overrun_o <= 1'b1;

            if ((state_reg == ACCUM) && close_w) begin
                n_b_reg <= n_b_w;
                d_b_reg <= d_b_w;
            end

            if (div_load) begin
                rem_reg  <= DW'(ld_n) << 8;
                dsh_reg  <= DW'(ld_d) << 15;
                q_reg    <= '0;
                ovf_reg  <= ld_ovf;
                dz_reg   <= ld_dz;
                iter_reg <= '0;
            end else if ((state_reg == DIV_R) || (state_reg == DIV_B)) begin
                rem_reg  <= rem_step;
                dsh_reg  <= dsh_reg >> 1;
                q_reg    <= q_step;
                iter_reg <= iter_reg + 4'd1;
            end

            // Final iteration result is captured as it is produced.
            if ((state_reg == DIV_R) && (iter_reg == 4'd15))
                q_r_reg <= finish_q(q_step, ovf_reg, dz_reg);
            if ((state_reg == DIV_B) && (iter_reg == 4'd15))
                q_b_reg <= finish_q(q_step, ovf_reg, dz_reg);

            if (state_reg == UPDATE) begin
                K_R          <= q_r_reg;
                K_B          <= q_b_reg;
                valid_gain_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_awb_gain_est.sv
// tb_awb_gain_est
// Randomized and directed stimulus for awb_gain_est with a queue-based
// scoreboard. The stimulus side predicts each frame's gains from plain
// per-channel averages; a monitor pops predictions when busy_o falls.
module tb_awb_gain_est;
    logic        clk;
    logic        rst;
    logic [15:0] K_R, K_G, K_B;
    logic        valid_gain_o, busy_o, overrun_o;

    awb_gain_est_if pix_if();

    awb_gain_est dut (
        .clk          (clk),
        .rst          (rst),
        .pix          (pix_if),
        .K_R          (K_R),
        .K_G          (K_G),
        .K_B          (K_B),
        .valid_gain_o (valid_gain_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          l;
        logic [15:0] kr;
        logic [15:0] kb;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    longint unsigned msum[3];
    longint unsigned mcnt[3];
    int              act_l = -1000;
    logic [15:0]     exp_kr = 16'h0100;
    logic [15:0]     exp_kb = 16'h0100;
    logic            exp_valid = 1'b0;
    logic            exp_ovr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Gain = average(G) / average(C) in 8.8, saturated to the output window.
    function automatic logic [15:0] gain(input longint unsigned n, input longint unsigned d);
        longint unsigned q;
        if (d == 0) return 16'h0100;
        q = (n * 256) / d;
        if (q > 4095) q = 4095;
`ifdef AWB_GAIN_CLAMP_EN
        if (q < 128) q = 128;
        if (q > 1024) q = 1024;
`endif
        return 16'(q);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            msum[c] = 0;
            mcnt[c] = 0;
        end
    endtask

    task automatic px(input logic [1:0] c, input logic [7:0] v, input logic l);
        int   e;
        exp_t x;
        @(negedge clk);
        #1;
        pix_if.valid_i = 1'b1;
        pix_if.color_i = c;
        pix_if.value_i = v;
        pix_if.last_i  = l;
        e = edge_cnt + 1;
        if (c != 2'd3) begin
            msum[c] += 64'(v);
            mcnt[c] += 1;
        end
        if (l) begin
            if (e > act_l + 33) begin
                x.l  = e;
                x.kr = gain(msum[1] * mcnt[0], msum[0] * mcnt[1]);
                x.kb = gain(msum[1] * mcnt[2], msum[2] * mcnt[1]);
                sb.push_back(x);
                act_l = e;
            end else begin
                exp_ovr = 1'b1;
            end
            model_clear();
        end
    endtask

    // Idle cycles carry random color/value/last with valid low.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            pix_if.valid_i = 1'b0;
            pix_if.color_i = 2'($urandom_range(0, 3));
            pix_if.value_i = 8'($urandom_range(0, 255));
            pix_if.last_i  = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: one result per busy_o falling edge, plus per-cycle output check.
    initial begin
        logic prev_busy;
        logic exp_busy;
        exp_t h;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy_o) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL update_expected actual=update_at_%0d required=none", edge_cnt);
                    end else begin
                        h = sb.pop_front();
                        chk("latency", 64'(edge_cnt), 64'(h.l + 33));
                        exp_kr    = h.kr;
                        exp_kb    = h.kb;
                        exp_valid = 1'b1;
                        $display("frame L=%0d update@%0d K_R=%h K_G=%h K_B=%h exp_K_R=%h exp_K_B=%h",
                                 h.l, edge_cnt, K_R, K_G, K_B, h.kr, h.kb);
                    end
                end
                if (sb.size() > 0 && edge_cnt > sb[0].l + 40) begin
                    chk("timeout", 64'(edge_cnt), 64'(sb[0].l + 33));
                    void'(sb.pop_front());
                end
                exp_busy = (edge_cnt >= act_l) && (edge_cnt <= act_l + 32);
                chk("outputs", {13'd0, K_R, K_G, K_B, valid_gain_o, busy_o, overrun_o},
                    {13'd0, exp_kr, 16'h0100, exp_kb, exp_valid, exp_busy, exp_ovr});
                prev_busy = busy_o;
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_K_R", 64'(K_R), 64'(16'h0100));
        chk("rst_K_G", 64'(K_G), 64'(16'h0100));
        chk("rst_K_B", 64'(K_B), 64'(16'h0100));
        chk("rst_valid", 64'(valid_gain_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_overrun", 64'(overrun_o), 64'(0));
    endtask

    initial begin
        int lr;
        rst = 1'b0;
        pix_if.valid_i = 1'b0;
        pix_if.color_i = 2'd0;
        pix_if.value_i = 8'd0;
        pix_if.last_i  = 1'b0;
        model_clear();
        #2 rst = 1'b1;
        #1 check_reset_values();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        idle(3);

        // Basic frame: K_R=2.0, K_B=4.0
        px(2'd0, 8'd64, 1'b0); px(2'd1, 8'd128, 1'b0);
        px(2'd1, 8'd128, 1'b0); px(2'd2, 8'd32, 1'b1);
        idle(40);

        // No red pixels: unity K_R, K_B=2.0
        px(2'd1, 8'd100, 1'b0); px(2'd1, 8'd100, 1'b0); px(2'd2, 8'd50, 1'b1);
        idle(40);

        // Saturating red gain
        px(2'd0, 8'd1, 1'b0); px(2'd1, 8'd255, 1'b0);
        px(2'd1, 8'd255, 1'b0); px(2'd2, 8'd255, 1'b1);
        idle(40);

        // Second frame streamed during division of the first
        px(2'd0, 8'd90, 1'b0); px(2'd1, 8'd45, 1'b0); px(2'd2, 8'd180, 1'b1);
        for (int i = 0; i < 8; i++)
            px(2'($urandom_range(0, 3)), 8'($urandom_range(1, 255)), 1'b0);
        idle(30);
        px(2'd0, 8'd10, 1'b0); px(2'd1, 8'd200, 1'b0); px(2'd2, 8'd77, 1'b1);
        idle(40);

        // Overrun: last at L+5 while busy
        px(2'd0, 8'd30, 1'b0); px(2'd1, 8'd60, 1'b0); px(2'd2, 8'd120, 1'b1);
        idle(4);
        px(2'd1, 8'd77, 1'b1);
        idle(40);
        px(2'd0, 8'd40, 1'b0); px(2'd1, 8'd120, 1'b0); px(2'd2, 8'd240, 1'b1);
        idle(40);

        // Reset mid-division aborts the frame
        px(2'd0, 8'd50, 1'b0); px(2'd1, 8'd150, 1'b0); px(2'd2, 8'd25, 1'b1);
        lr = act_l;
        @(posedge clk);
        #1;
        pix_if.valid_i = 1'b0;
        pix_if.last_i  = 1'b0;
        while (edge_cnt < lr + 10) begin
            @(posedge clk);
            #1;
        end
        #1 rst = 1'b1;
        sb.delete();
        act_l = -1000;
        exp_kr = 16'h0100;
        exp_kb = 16'h0100;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        model_clear();
        #1 check_reset_values();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        idle(40);

        // Random frames with random gaps (some closing while busy)
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int p = 0; p < len; p++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                px(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'(p == len - 1));
            end
            idle($urandom_range(1, 45));
        end
        idle(50);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
